// File: rtl/motoro3_pwm_capture.sv
// rtl/motoro3_pwm_capture.sv - PWM pulse high-time/period capture with per-step on-time accumulation
// Optional glitch filter on the synchronized line: define MOTORO3_PWM_CAP_GLITCH_EN
module motoro3_pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_MIN  = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             capEnable,
  input  logic             pwmIn,
  input  logic             stepStrobe,
  input  logic [11:0]      minPulseLen,
  output logic [CNT_W-1:0] pulseHigh,
  output logic [CNT_W-1:0] pulsePeriod,
  output logic             pulseValid,
  output logic             shortPulse,
  output logic [CNT_W-1:0] stepOnSum,
  output logic [7:0]       stepPulseCnt,
  output logic             stepValid,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAXC = '1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || GLITCH_MIN < 1 || CNT_W < 12) begin : gBadParam
    $error("motoro3_pwm_capture: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, LOW, HIGH} stateT;

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   pwmS;
  logic                   line;
  logic                   linePrev;
  logic                   rise;
  logic                   fall;
  logic                   pulseDone;
  stateT                  state;
  logic [CNT_W-1:0]       perCnt;
  logic [CNT_W-1:0]       highCnt;
  logic [CNT_W-1:0]       periodShadow;
  logic [CNT_W-1:0]       onAcc;
  logic [7:0]             pulseCnt;
  logic                   havePrev;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) syncReg <= '0;
    else       syncReg <= {syncReg[SYNC_STAGES-2:0], pwmIn};
  end

  assign pwmS = syncReg[SYNC_STAGES-1];

`ifdef MOTORO3_PWM_CAP_GLITCH_EN
  localparam int GW = $clog2(GLITCH_MIN + 1);
  logic          pwmF;
  logic [GW-1:0] glitchCnt;

  // pwmF follows pwmS only after GLITCH_MIN consecutive cycles of disagreement
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      pwmF      <= 1'b0;
      glitchCnt <= '0;
    end else if (pwmS != pwmF) begin
      if (glitchCnt == GW'(GLITCH_MIN - 1)) begin
        pwmF      <= pwmS;
        glitchCnt <= '0;
      end else begin
        glitchCnt <= glitchCnt + 1'b1;
      end
    end else begin
      glitchCnt <= '0;
    end
  end

  assign line = pwmF;
`else
  assign line = pwmS;
`endif

  assign rise      = line & ~linePrev;
  assign fall      = ~line & linePrev;
  assign pulseDone = (state == HIGH) && fall;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      linePrev     <= 1'b0;
      state        <= IDLE;
      perCnt       <= '0;
      highCnt      <= '0;
      periodShadow <= '0;
      onAcc        <= '0;
      pulseCnt     <= '0;
      havePrev     <= 1'b0;
      pulseHigh    <= '0;
      pulsePeriod  <= '0;
      pulseValid   <= 1'b0;
      shortPulse   <= 1'b0;
      stepOnSum    <= '0;
      stepPulseCnt <= '0;
      stepValid    <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      linePrev   <= line;
      pulseValid <= 1'b0;
      stepValid  <= 1'b0;
      if (!capEnable) begin
        // Latched results hold; everything that measures restarts from scratch
        state        <= IDLE;
        perCnt       <= '0;
        highCnt      <= '0;
        periodShadow <= '0;
        onAcc        <= '0;
        pulseCnt     <= '0;
        havePrev     <= 1'b0;
        ovf          <= 1'b0;
      end else begin
        if (stepStrobe) begin
          stepOnSum    <= onAcc;
          stepPulseCnt <= pulseCnt;
          stepValid    <= 1'b1;
          onAcc        <= {{(CNT_W-1){1'b0}}, line};
          pulseCnt     <= {7'd0, pulseDone};
        end else begin
          if (line) begin
            if (onAcc == MAXC) ovf <= 1'b1;
            else               onAcc <= onAcc + 1'b1;
          end
          if (pulseDone && pulseCnt != 8'hFF) pulseCnt <= pulseCnt + 1'b1;
        end

        if (state != IDLE) begin
          if (perCnt == MAXC) ovf <= 1'b1;
          else                perCnt <= perCnt + 1'b1;
        end

        case (state)
          IDLE: begin
            if (!line) begin
              state   <= LOW;
              perCnt  <= '0;
              highCnt <= '0;
            end
          end
          LOW: begin
            if (rise) begin
              state        <= HIGH;
              highCnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
              periodShadow <= !havePrev ? '0 : (perCnt == MAXC) ? MAXC : perCnt + 1'b1;
              perCnt       <= '0;
              havePrev     <= 1'b1;
            end
          end
          HIGH: begin
            if (fall) begin
              state       <= LOW;
              pulseHigh   <= highCnt;
              pulsePeriod <= periodShadow;
              pulseValid  <= 1'b1;
              shortPulse  <= highCnt < CNT_W'(minPulseLen);
            end else if (highCnt == MAXC) begin
              ovf <= 1'b1;
            end else begin
              highCnt <= highCnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// tb/tb_motoro3_pwm_capture.sv - self-checking bench for motoro3_pwm_capture
// Delays and filter expectations follow MOTORO3_PWM_CAP_GLITCH_EN when defined
module tb_motoro3_pwm_capture;

`ifdef MOTORO3_PWM_CAP_GLITCH_EN
  localparam int DLY  = 2 + 3;
  localparam int HMIN = 3;
`else
  localparam int DLY  = 2;
  localparam int HMIN = 1;
`endif

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        capEnable = 1'b0;
  logic        pwmIn = 1'b0;
  logic        stepStrobe = 1'b0;
  logic [11:0] minPulseLen = 12'd0;
  logic [15:0] pulseHigh;
  logic [15:0] pulsePeriod;
  logic        pulseValid;
  logic        shortPulse;
  logic [15:0] stepOnSum;
  logic [7:0]  stepPulseCnt;
  logic        stepValid;
  logic        ovf;

  motoro3_pwm_capture dut (
    .clk(clk), .nRst(nRst), .capEnable(capEnable), .pwmIn(pwmIn),
    .stepStrobe(stepStrobe), .minPulseLen(minPulseLen),
    .pulseHigh(pulseHigh), .pulsePeriod(pulsePeriod), .pulseValid(pulseValid),
    .shortPulse(shortPulse), .stepOnSum(stepOnSum), .stepPulseCnt(stepPulseCnt),
    .stepValid(stepValid), .ovf(ovf)
  );

  always #50 clk = ~clk;

  typedef struct { logic [15:0] hi; logic [15:0] per; logic sp; } pulseRecT;
  typedef struct { logic [15:0] sum; logic [7:0] cnt; } stepRecT;
  typedef struct { int high; int period; int minLen; logic [15:0] expHigh; logic [15:0] expPer; logic expShort; } vecT;

  pulseRecT pulseQ[$];
  stepRecT  stepQ[$];
  bit       pinH[$];
  bit       strH[$];
  int       errors = 0;
  int       checks = 0;

  // DUT outputs settle on negedge, so posedge is a safe sampling point
  always @(posedge clk) begin
    if (pulseValid) pulseQ.push_back('{hi: pulseHigh, per: pulsePeriod, sp: shortPulse});
    if (stepValid)  stepQ.push_back('{sum: stepOnSum, cnt: stepPulseCnt});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit s);
    @(posedge clk);
    pwmIn = p;
    stepStrobe = s;
    pinH.push_back(p);
    strH.push_back(s);
  endtask

  task automatic seg(input bit lvl, input int n, input int strobeAt);
    for (int i = 0; i < n; i++) drive(lvl, i == strobeAt);
  endtask

  task automatic restart(input logic [11:0] ml);
    capEnable = 1'b0;
    seg(0, 4, -1);
    pulseQ.delete();
    stepQ.delete();
    pinH.delete();
    strH.delete();
    minPulseLen = ml;
    drive(0, 0);
    capEnable = 1'b1;
  endtask

  // Reference: the line the capture logic sees is the pin delayed by DLY clocks.
  // Pulses and step totals are derived from edge timestamps and interval sums.
  task automatic checkRandom(input int minLen);
    bit lv[$];
    bit fl[$];
    pulseRecT expP[$];
    stepRecT  expS[$];
    int n, riseT, prevRise, m, sum, cnt, hw;
    n = pinH.size();
    for (int j = 0; j < n; j++) lv.push_back(j >= DLY ? pinH[j-DLY] : 1'b0);
    riseT = -1;
    prevRise = -1;
    fl.push_back(1'b0);
    for (int j = 1; j < n; j++) begin
      fl.push_back(1'b0);
      if (lv[j] && !lv[j-1]) begin
        prevRise = riseT;
        riseT = j;
      end
      if (!lv[j] && lv[j-1] && riseT >= 0) begin
        fl[j] = 1'b1;
        hw = j - riseT;
        expP.push_back('{hi: 16'(hw), per: 16'(prevRise < 0 ? 0 : riseT - prevRise), sp: hw < minLen});
      end
    end
    m = 0;
    for (int j = 0; j < n; j++) begin
      if (strH[j]) begin
        sum = 0;
        cnt = 0;
        for (int k = m; k < j; k++) begin
          sum += lv[k];
          cnt += fl[k];
        end
        expS.push_back('{sum: 16'(sum), cnt: 8'(cnt)});
        m = j;
      end
    end
    chk("rnd_pulse_count", pulseQ.size(), expP.size());
    for (int i = 0; i < expP.size() && i < pulseQ.size(); i++) begin
      chk("rnd_high", pulseQ[i].hi, expP[i].hi);
      chk("rnd_period", pulseQ[i].per, expP[i].per);
      chk("rnd_short", pulseQ[i].sp, expP[i].sp);
    end
    chk("rnd_step_count", stepQ.size(), expS.size());
    for (int i = 0; i < expS.size() && i < stepQ.size(); i++) begin
      chk("rnd_step_sum", stepQ[i].sum, expS[i].sum);
      chk("rnd_step_cnt", stepQ[i].cnt, expS[i].cnt);
    end
  endtask

  initial begin
    vecT vecs[5];
    int  ml;
    vecs[0] = '{32, 511, 64, 16'd32, 16'd511, 1'b1};
    vecs[1] = '{64, 150, 64, 16'd64, 16'd150, 1'b0};
    vecs[2] = '{63, 150, 64, 16'd63, 16'd150, 1'b1};
    vecs[3] = '{5, 17, 1, 16'd5, 16'd17, 1'b0};
    vecs[4] = '{40, 43, 4095, 16'd40, 16'd43, 1'b1};

    // Reset values
    repeat (2) @(posedge clk);
    chk("rst_pulseHigh", pulseHigh, 0);
    chk("rst_pulsePeriod", pulsePeriod, 0);
    chk("rst_pulseValid", pulseValid, 0);
    chk("rst_shortPulse", shortPulse, 0);
    chk("rst_stepOnSum", stepOnSum, 0);
    chk("rst_stepPulseCnt", stepPulseCnt, 0);
    chk("rst_stepValid", stepValid, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    nRst = 1'b1;

    // Periodic trains from the vector table
    foreach (vecs[v]) begin
      restart(vecs[v].minLen[11:0]);
      seg(0, 20, -1);
      for (int p = 0; p < 3; p++) begin
        seg(1, vecs[v].high, -1);
        seg(0, vecs[v].period - vecs[v].high, -1);
      end
      seg(0, DLY + 3, -1);
      chk("vec_pulse_count", pulseQ.size(), 3);
      for (int p = 0; p < 3 && p < pulseQ.size(); p++) begin
        chk("vec_high", pulseQ[p].hi, vecs[v].expHigh);
        chk("vec_period", pulseQ[p].per, p == 0 ? 16'd0 : vecs[v].expPer);
        chk("vec_short", pulseQ[p].sp, vecs[v].expShort);
      end
    end

    // Pulse spanning a step boundary
    restart(12'd64);
    seg(0, 20, -1);
    for (int p = 0; p < 4; p++) begin
      seg(1, 300, -1);
      seg(0, 211, -1);
    end
    seg(1, 300, DLY + 100);
    seg(0, 211, 100);
    seg(0, 5, -1);
    chk("split_step_count", stepQ.size(), 2);
    if (stepQ.size() >= 2) begin
      chk("split_sum0", stepQ[0].sum, 1300);
      chk("split_cnt0", stepQ[0].cnt, 4);
      chk("split_sum1", stepQ[1].sum, 200);
      chk("split_cnt1", stepQ[1].cnt, 1);
    end

    // Line already high at enable is not a pulse
    capEnable = 1'b0;
    seg(1, 20, -1);
    pulseQ.delete();
    capEnable = 1'b1;
    seg(1, 30, -1);
    seg(0, 50, -1);
    seg(1, 40, -1);
    seg(0, 20, -1);
    chk("prehigh_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) begin
      chk("prehigh_high", pulseQ[0].hi, 40);
      chk("prehigh_period", pulseQ[0].per, 0);
    end

    // Glitch / narrow pulse
    restart(12'd4);
    seg(0, 20, -1);
    seg(1, 2, -1);
    seg(0, 20, 15);
    seg(0, 5, -1);
    chk("spike_step_count", stepQ.size(), 1);
    if (stepQ.size() >= 1) begin
`ifdef MOTORO3_PWM_CAP_GLITCH_EN
      chk("spike_step_sum", stepQ[0].sum, 0);
`else
      chk("spike_step_sum", stepQ[0].sum, 2);
`endif
    end
`ifdef MOTORO3_PWM_CAP_GLITCH_EN
    chk("spike_pulse_count", pulseQ.size(), 0);
`else
    chk("spike_pulse_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) chk("spike_high", pulseQ[0].hi, 2);
`endif
    pulseQ.delete();
    seg(1, 10, -1);
    seg(0, 20, -1);
    chk("ten_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) chk("ten_high", pulseQ[0].hi, 10);

    // Randomized pulse trains against the reference model
    for (int r = 0; r < 2; r++) begin
      ml = $urandom_range(1, 80);
      restart(12'(ml));
      seg(0, 10, -1);
      for (int p = 0; p < 30; p++) begin
        int hl;
        int ll;
        hl = $urandom_range(HMIN, 80);
        ll = $urandom_range(HMIN > 1 ? HMIN : 1, 60);
        for (int i = 0; i < hl; i++) drive(1, $urandom_range(0, 49) == 0);
        for (int i = 0; i < ll; i++) drive(0, $urandom_range(0, 49) == 0);
      end
      seg(0, DLY + 5, -1);
      drive(0, 1);
      seg(0, 3, -1);
      checkRandom(ml);
      chk("rnd_ovf", ovf, 0);
    end

    // Abort mid-pulse by dropping capEnable
    restart(12'd8);
    seg(0, 20, -1);
    seg(1, 15, -1);
    seg(0, 30, -1);
    seg(1, DLY + 10, -1);
    capEnable = 1'b0;
    seg(1, 5, -1);
    seg(0, 20, -1);
    chk("abort_count", pulseQ.size(), 1);
    chk("abort_hold_high", pulseHigh, 15);
    pulseQ.delete();
    capEnable = 1'b1;
    seg(0, 30, -1);
    seg(1, 25, -1);
    seg(0, 30, -1);
    chk("abort_next_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) begin
      chk("abort_next_high", pulseQ[0].hi, 25);
      chk("abort_next_period", pulseQ[0].per, 0);
    end

    // Asynchronous reset mid-pulse
    seg(1, 10, -1);
    #20 nRst = 1'b0;
    pwmIn = 1'b0;
    #5;
    chk("arst_pulseHigh", pulseHigh, 0);
    chk("arst_stepOnSum", stepOnSum, 0);
    pulseQ.delete();
    @(posedge clk);
    nRst = 1'b1;
    seg(0, 20, -1);
    seg(1, 12, -1);
    seg(0, 20, -1);
    chk("arst_next_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) begin
      chk("arst_next_high", pulseQ[0].hi, 12);
      chk("arst_next_period", pulseQ[0].per, 0);
    end

    // Counter saturation and sticky ovf
    restart(12'd64);
    seg(0, 10, -1);
    seg(1, 70000, -1);
    seg(0, 20, -1);
    chk("sat_count", pulseQ.size(), 1);
    if (pulseQ.size() >= 1) begin
      chk("sat_high", pulseQ[0].hi, 16'hFFFF);
      chk("sat_period", pulseQ[0].per, 0);
    end
    chk("sat_ovf", ovf, 1);
    seg(0, 50, -1);
    chk("sat_ovf_sticky", ovf, 1);
    capEnable = 1'b0;
    seg(0, 2, -1);
    chk("sat_ovf_cleared", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motoro3_pwm_capture.md
Name: motoro3_pwm_capture

Overview:
- Receive-side counterpart of the 3-phase PWM generator. Samples a PWM line (looped back from the MOSFET gate-driver input or the FPGA pin) and measures each pulse's high time and period.
- Accumulates the delivered on-time per commutation step and reports it at each step boundary, so the controller can compare wanted against delivered position.
- Flags pulses shorter than the minimum MOSFET-usable width.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on pwmIn (legal 2..3).
- GLITCH_MIN, 3: minimum stable cycles for the glitch filter (used only with the optional feature).
- CNT_W, 16: width of all time counters.

Ports:
- clk  in  1  10 MHz clock. All flops on negedge clk.
- nRst  in  1  reset, asynchronous, active-low.
- capEnable  in  1  0: counters held cleared, FSM forced to IDLE, no strobes.
- pwmIn  in  1  asynchronous PWM line under measurement.
- stepStrobe  in  1  one-cycle strobe at commutation step boundary (m3cntLast2 timing).
- minPulseLen  in  12  short-pulse threshold in clocks.
- pulseHigh  out  16  last measured high width in clocks.
- pulsePeriod  out  16  last rising-to-rising period in clocks; 0 if no previous rise.
- pulseValid  out  1  one-cycle strobe: pulseHigh/pulsePeriod updated.
- shortPulse  out  1  registered with pulseValid: pulseHigh < minPulseLen.
- stepOnSum  out  16  high clocks delivered in the completed step.
- stepPulseCnt  out  8  complete pulses (falling edges) in the completed step.
- stepValid  out  1  one-cycle strobe: step outputs updated.
- ovf  out  1  sticky: a counter saturated. Cleared only by reset or capEnable=0.

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Internal counters 0. Synchronizer flops 0.
- pwmS = pwmIn after SYNC_STAGES flops. Edges are detected against the previous pwmS. Latency from pin to edge detect is SYNC_STAGES+1 cycles.
- FSM states and transitions:
  - IDLE: wait for pwmS=0, then go to LOW. A line already high at enable is never measured as a partial pulse.
  - LOW: on rise, go to HIGH. highCnt loads 1.
    - If a previous rise exists (havePrev=1), latch perCnt+1 into periodShadow; otherwise periodShadow=0.
    - perCnt loads 0. Set havePrev.
  - HIGH: highCnt increments each cycle. On fall, go to LOW.
    - pulseHigh <= highCnt; pulsePeriod <= periodShadow.
    - pulseValid=1 for one cycle. shortPulse <= (highCnt < {4'd0,minPulseLen}).
    - Step pulse counter +1.
- perCnt increments every cycle in LOW and HIGH.
- Saturation: perCnt and highCnt stop at 0xFFFF and set ovf. A saturated value is reported as 0xFFFF. The step pulse counter stops at 0xFF and does not set ovf.
- Step accumulator onAcc increments each cycle pwmS=1 while capEnable=1. It saturates at 0xFFFF and sets ovf.
- On stepStrobe:
  - stepOnSum <= onAcc; stepPulseCnt <= step pulse counter; stepValid=1 for one cycle.
  - onAcc restarts at 1 if pwmS=1 that cycle, else 0. The pulse counter restarts at 1 if a fall occurs that cycle, else 0.
- A pulse spanning a step boundary: its high clocks are split between the two steps; its pulse count goes to the step in which it falls.
- stepStrobe and a falling edge in the same cycle: both strobes fire; the pulse is counted in the new step.
- capEnable falling mid-pulse: the in-flight pulse is discarded with no pulseValid, and FSM goes to IDLE. Already-latched outputs hold their values.
- nRst asserted mid-operation: immediate clear to reset values. After release, the FSM starts in IDLE.

Optional Feature:
- Macro: MOTORO3_PWM_CAP_GLITCH_EN.
- Defined: the FSM uses pwmF instead of pwmS. pwmF changes only after pwmS has differed from pwmF for GLITCH_MIN consecutive cycles. Each edge is therefore delayed by GLITCH_MIN cycles, and high pulses shorter than GLITCH_MIN are invisible (no pulseValid, not counted). onAcc also counts pwmF.
- Undefined: no filter. Every synchronized edge is measured, including 1-cycle pulses.

Test Plan:
- Periodic PWM, high 32 / period 511 clocks, minPulseLen=64, 3 periods: 3 pulseValid strobes. pulseHigh=32 each. pulsePeriod=0, then 511, 511. shortPulse=1 on all three.
- High 300 / period 511, stepStrobe after 4 complete pulses plus 100 clocks into the 5th high: stepOnSum=1300, stepPulseCnt=4. The following step then reports 200 high clocks from the 5th pulse, counted there.
- pwmIn held high before capEnable=1, then low 50, high 40: exactly one pulseValid with pulseHigh=40 and pulsePeriod=0.
- pwmIn high for 70000 clocks then low: pulseHigh=0xFFFF, ovf=1, and ovf stays set until capEnable=0.
- capEnable cleared 10 clocks into a high pulse, re-enabled with line low: no pulseValid for the aborted pulse. The next pulse reports pulsePeriod=0.
- With MOTORO3_PWM_CAP_GLITCH_EN defined and GLITCH_MIN=3: 2-clock spike gives no pulseValid and stepOnSum unchanged. A 10-clock pulse gives pulseHigh=10. Without the macro, the 2-clock spike gives pulseHigh=2.
